// File: rtl/dsp_cfg_mgmt_bus_num_writer_if.sv
// Request handshake plus DSP configuration-management access port of the bus-number writer.
// The writer is the master; the requester and config space together form the slave side.
interface dsp_cfg_mgmt_bus_num_writer_if;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_pri_bus;
    logic [7:0]  req_sec_bus;
    logic [7:0]  req_sub_bus;
    logic [9:0]  dsp_cfg_mgmt_addr;
    logic [7:0]  dsp_cfg_mgmt_function_number;
    logic        dsp_cfg_mgmt_write;
    logic        dsp_cfg_mgmt_read;
    logic [31:0] dsp_cfg_mgmt_write_data;
    logic [3:0]  dsp_cfg_mgmt_byte_enable;
    logic [31:0] dsp_cfg_mgmt_read_data;
    logic        dsp_cfg_mgmt_read_write_done;

    modport master (
        input  req_valid, req_pri_bus, req_sec_bus, req_sub_bus,
               dsp_cfg_mgmt_read_data, dsp_cfg_mgmt_read_write_done,
        output req_ready, dsp_cfg_mgmt_addr, dsp_cfg_mgmt_function_number,
               dsp_cfg_mgmt_write, dsp_cfg_mgmt_read, dsp_cfg_mgmt_write_data,
               dsp_cfg_mgmt_byte_enable
    );

    modport slave (
        output req_valid, req_pri_bus, req_sec_bus, req_sub_bus,
               dsp_cfg_mgmt_read_data, dsp_cfg_mgmt_read_write_done,
        input  req_ready, dsp_cfg_mgmt_addr, dsp_cfg_mgmt_function_number,
               dsp_cfg_mgmt_write, dsp_cfg_mgmt_read, dsp_cfg_mgmt_write_data,
               dsp_cfg_mgmt_byte_enable
    );
endinterface

// File: rtl/dsp_cfg_mgmt_bus_num_writer.sv
// Writes primary/secondary/subordinate bus numbers to config DWORD 0x006, reads them
// back to verify, and retries on mismatch or access timeout.
module dsp_cfg_mgmt_bus_num_writer #(
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic                          dsp_user_clk,
    input  logic                          sys_reset_n,
    dsp_cfg_mgmt_bus_num_writer_if.master bus,
    output logic                          wb_done,
    output logic                          wb_error,
    output logic [1:0]                    retry_count
);
    typedef enum logic [2:0] {IDLE, WR, RD, CMP, DONE, ERR} state_t;

    localparam int unsigned      TMO_W         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST      = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [1:0]       RETRY_LIMIT   = 2'(MAX_RETRIES);
    localparam logic [9:0]       BUS_NUM_DWORD = 10'h006;

    state_t           state_q;
    state_t           state_d;
    logic [7:0]       pri_q;
    logic [7:0]       sec_q;
    logic [7:0]       sub_q;
    logic [23:0]      readback_q;
    logic             readback_valid_q;
    logic [TMO_W-1:0] tmo_cnt_q;
    logic [1:0]       retry_q;

    logic accept;
    logic access_done;
    logic tmo_hit;
    logic match;
    logic in_access;
    logic unused_read_data_hi;

    assign accept      = (state_q == IDLE) && bus.req_valid;
    assign access_done = bus.dsp_cfg_mgmt_read_write_done;
    assign tmo_hit     = (tmo_cnt_q == TMO_LAST);
    assign in_access   = (state_q == WR) || (state_q == RD);
    // A timed-out attempt never sets readback_valid_q, so it fails the compare too.
    assign match       = readback_valid_q && (readback_q == {sub_q, sec_q, pri_q});
    assign unused_read_data_hi = ^bus.dsp_cfg_mgmt_read_data[31:24];

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge dsp_user_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d takes a default before the case so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.req_valid) state_d = WR;
            WR: begin
                if (access_done)  state_d = RD;
                else if (tmo_hit) state_d = CMP;
            end
            RD:   if (access_done || tmo_hit) state_d = CMP;
            CMP: begin
                if (match)                      state_d = DONE;
                else if (retry_q < RETRY_LIMIT) state_d = WR;
                else                            state_d = ERR;
            end
            DONE, ERR: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge dsp_user_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            pri_q            <= '0;
            sec_q            <= '0;
            sub_q            <= '0;
            readback_q       <= '0;
            readback_valid_q <= 1'b0;
            tmo_cnt_q        <= '0;
            retry_q          <= '0;
        end else begin
            // Restart the timeout window on every entry into WR or RD.
            tmo_cnt_q <= (in_access && (state_d == state_q)) ? tmo_cnt_q + 1'b1 : '0;
            if (accept) begin
                pri_q            <= bus.req_pri_bus;
                sec_q            <= bus.req_sec_bus;
                sub_q            <= bus.req_sub_bus;
                readback_q       <= '0;
                readback_valid_q <= 1'b0;
                retry_q          <= '0;
            end
            if ((state_q == RD) && access_done) begin
                readback_q       <= bus.dsp_cfg_mgmt_read_data[23:0];
                readback_valid_q <= 1'b1;
            end
            if ((state_q == CMP) && (state_d == WR)) begin
                retry_q          <= retry_q + 1'b1;
                readback_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.req_ready                    = (state_q == IDLE) && sys_reset_n;
        bus.dsp_cfg_mgmt_addr            = '0;
        bus.dsp_cfg_mgmt_function_number = '0;
        bus.dsp_cfg_mgmt_write           = 1'b0;
        bus.dsp_cfg_mgmt_read            = 1'b0;
        bus.dsp_cfg_mgmt_write_data      = '0;
        bus.dsp_cfg_mgmt_byte_enable     = '0;
        wb_done                          = 1'b0;
        wb_error                         = 1'b0;
        unique case (state_q)
            WR: begin
                bus.dsp_cfg_mgmt_write       = 1'b1;
                bus.dsp_cfg_mgmt_addr        = BUS_NUM_DWORD;
                bus.dsp_cfg_mgmt_byte_enable = 4'b0111;
                bus.dsp_cfg_mgmt_write_data  = {8'h00, sub_q, sec_q, pri_q};
            end
            RD: begin
                bus.dsp_cfg_mgmt_read        = 1'b1;
                bus.dsp_cfg_mgmt_addr        = BUS_NUM_DWORD;
                bus.dsp_cfg_mgmt_byte_enable = 4'b1111;
            end
            DONE:    wb_done  = 1'b1;
            ERR:     wb_error = 1'b1;
            default: ;
        endcase
    end

    assign retry_count = retry_q;
endmodule

// File: tb/tb_dsp_cfg_mgmt_bus_num_writer.sv
// Self-checking bench: config-space responder with per-attempt done delays and readback
// corruption, a directed vector table, hand-written corner sequences and random operations.
`timescale 1ns/1ps
module tb_dsp_cfg_mgmt_bus_num_writer;
    localparam int         T     = 15;
    localparam int         R     = 3;
    localparam logic [7:0] NEVER = 8'd255;

    // Per-attempt done delays (cycles after strobe rise; NEVER = no done) and corrupt-readback mask.
    typedef struct packed {
        logic [7:0]      pri;
        logic [7:0]      sec;
        logic [7:0]      sub;
        logic [3:0][7:0] wdly;
        logic [3:0][7:0] rdly;
        logic [3:0]      bad;
        logic            exp_ok;
        logic [1:0]      exp_retry;
        logic [2:0]      exp_writes;
        logic [7:0]      exp_lat;
        logic [4:0]      exp_run;
    } vec_t;

    logic       dsp_user_clk = 1'b0;
    logic       sys_reset_n  = 1'b1;
    logic       wb_done;
    logic       wb_error;
    logic [1:0] retry_count;

    dsp_cfg_mgmt_bus_num_writer_if bus ();

    dsp_cfg_mgmt_bus_num_writer #(.TIMEOUT_CYCLES(T), .MAX_RETRIES(R)) dut (
        .dsp_user_clk (dsp_user_clk),
        .sys_reset_n  (sys_reset_n),
        .bus          (bus),
        .wb_done      (wb_done),
        .wb_error     (wb_error),
        .retry_count  (retry_count)
    );

    always #5 dsp_user_clk = ~dsp_user_clk;

    int   n_checks    = 0;
    int   n_fail      = 0;
    vec_t cur         = '0;
    bit   noise       = 1'b0;
    int   writes      = 0;
    int   wr_run_max  = 0;
    int   viols       = 0;
    int   dcnt        = 0;
    int   ecnt        = 0;
    int   run         = 0;
    int   att         = 0;
    bit   prev_wr     = 1'b0;
    bit   prev_rd     = 1'b0;

    // Config-space responder and protocol monitor, active on the falling edge.
    always @(negedge dsp_user_clk) begin
        logic [23:0] exp_data;
        exp_data = {cur.sub, cur.sec, cur.pri};
        bus.dsp_cfg_mgmt_read_write_done = 1'b0;
        bus.dsp_cfg_mgmt_read_data       = 32'h0;
        if (bus.dsp_cfg_mgmt_write && bus.dsp_cfg_mgmt_read) viols++;
        if (bus.dsp_cfg_mgmt_function_number != 8'd0) viols++;
        if (bus.dsp_cfg_mgmt_write) begin
            if (!prev_wr) begin
                att = (writes > 3) ? 3 : writes;
                writes++;
                run = 0;
            end
            run++;
            if (run > wr_run_max) wr_run_max = run;
            if (bus.dsp_cfg_mgmt_addr != 10'h006 || bus.dsp_cfg_mgmt_byte_enable != 4'b0111 ||
                bus.dsp_cfg_mgmt_write_data != {8'h00, exp_data}) viols++;
            if (run - 1 == int'(cur.wdly[att])) bus.dsp_cfg_mgmt_read_write_done = 1'b1;
        end else if (bus.dsp_cfg_mgmt_read) begin
            if (!prev_rd) run = 0;
            run++;
            if (bus.dsp_cfg_mgmt_addr != 10'h006 || bus.dsp_cfg_mgmt_byte_enable != 4'b1111) viols++;
            if (run - 1 == int'(cur.rdly[att])) begin
                bus.dsp_cfg_mgmt_read_write_done = 1'b1;
                bus.dsp_cfg_mgmt_read_data = {8'($urandom), cur.bad[att] ? ~exp_data : exp_data};
            end
        end else begin
            if (bus.dsp_cfg_mgmt_addr != 10'h0 || bus.dsp_cfg_mgmt_byte_enable != 4'h0 ||
                bus.dsp_cfg_mgmt_write_data != 32'h0) viols++;
            if (noise) bus.dsp_cfg_mgmt_read_write_done = 1'($urandom_range(0, 1));
        end
        if (wb_done)  dcnt++;
        if (wb_error) ecnt++;
        prev_wr = bus.dsp_cfg_mgmt_write;
        prev_rd = bus.dsp_cfg_mgmt_read;
    end

    task automatic check(input string tag, input string what, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %0d, expected %0d", tag, what, act, exp);
        end
    endtask

    task automatic clear_counts();
        writes = 0; wr_run_max = 0; viols = 0; dcnt = 0; ecnt = 0;
    endtask

    function automatic vec_t mk(input logic [23:0] bus_num, input int wd, input int rd,
                                input logic [3:0] bad, input bit ok, input int retry,
                                input int wrs, input int lat, input int run_len);
        vec_t v;
        v = '0;
        {v.sub, v.sec, v.pri} = bus_num;
        for (int k = 0; k < 4; k++) begin
            v.wdly[k] = 8'(wd);
            v.rdly[k] = 8'(rd);
        end
        v.bad        = bad;
        v.exp_ok     = ok;
        v.exp_retry  = 2'(retry);
        v.exp_writes = 3'(wrs);
        v.exp_lat    = 8'(lat);
        v.exp_run    = 5'(run_len);
        return v;
    endfunction

    // Reference: an access finishes after delay+1 cycles or times out after T+1 cycles; each
    // attempt then spends one compare cycle; the op ends with one DONE/ERR cycle.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int   lat;
        int   run_max;
        int   n;
        bit   ok;
        r = v; lat = 1; run_max = 0; n = 0; ok = 1'b0;
        for (int k = 0; k <= R; k++) begin
            if (!ok) begin
                int wd = int'(v.wdly[k]);
                int rd = int'(v.rdly[k]);
                n++;
                if (wd > T) begin
                    lat += T + 2;
                    if (T + 1 > run_max) run_max = T + 1;
                end else begin
                    if (wd + 1 > run_max) run_max = wd + 1;
                    if (rd > T) lat += wd + T + 3;
                    else begin
                        lat += wd + rd + 3;
                        ok = !v.bad[k];
                    end
                end
            end
        end
        r.exp_ok     = ok;
        r.exp_retry  = 2'(n - 1);
        r.exp_writes = 3'(n);
        r.exp_lat    = 8'(lat);
        r.exp_run    = 5'(run_max);
        return r;
    endfunction

    // Entered and left at posedge+2.
    task automatic run_op(input vec_t v, input string tag);
        int n;
        cur = v;
        clear_counts();
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(posedge dsp_user_clk); #2; n++;
        end
        check(tag, "ready", int'(bus.req_ready), 1);
        bus.req_valid   = 1'b1;
        bus.req_pri_bus = v.pri;
        bus.req_sec_bus = v.sec;
        bus.req_sub_bus = v.sub;
        n = 0;
        do begin
            @(posedge dsp_user_clk); #2; n++;
            bus.req_valid = 1'b0;
        end while (!wb_done && !wb_error && n < 400);
        check(tag, "status", int'({wb_done, wb_error}), v.exp_ok ? 2 : 1);
        check(tag, "latency", n, int'(v.exp_lat));
        check(tag, "retry", int'(retry_count), int'(v.exp_retry));
        @(posedge dsp_user_clk); #2;
        check(tag, "idle_ready", int'(bus.req_ready), 1);
        check(tag, "retry_hold", int'(retry_count), int'(v.exp_retry));
        check(tag, "writes", writes, int'(v.exp_writes));
        check(tag, "write_cycles", wr_run_max, int'(v.exp_run));
        check(tag, "pulses", dcnt * 16 + ecnt, v.exp_ok ? 16 : 1);
        check(tag, "protocol", viols, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        vec_t v;
        int   n;
        int   busy_ready;

        vecs[0] = mk(24'h050201,     3, 3, 4'b0000, 1, 0, 1, 10,  4);
        vecs[1] = mk(24'h050201,     3, 3, 4'b0001, 1, 1, 2, 19,  4);
        vecs[2] = mk(24'h0a0908, NEVER, 0, 4'b0000, 0, 3, 4, 69, 16);
        vecs[3] = mk(24'h332211,    15, 0, 4'b0000, 1, 0, 1, 19, 16);
        vecs[4] = mk(24'h000000,     0, 0, 4'b0000, 1, 0, 1,  4,  1);
        vecs[5] = mk(24'hc0ffee,     0, 0, 4'b0000, 1, 1, 2, 22,  1);
        vecs[5].rdly[0] = NEVER;
        vecs[6] = mk(24'h123456,     1, 1, 4'b1111, 0, 3, 4, 21,  2);
        vecs[7] = mk(24'hfedcba,     0, 0, 4'b0111, 1, 3, 4, 13,  1);
        vecs[8] = mk(24'h010203,    16, 0, 4'b0000, 0, 3, 4, 69, 16);

        bus.req_valid = 1'b0;
        bus.req_pri_bus = 8'h0; bus.req_sec_bus = 8'h0; bus.req_sub_bus = 8'h0;

        // Reset behaviour.
        #3 sys_reset_n = 1'b0;
        #1;
        check("reset", "ready_low", int'(bus.req_ready), 0);
        check("reset", "strobes", int'({bus.dsp_cfg_mgmt_write, bus.dsp_cfg_mgmt_read}), 0);
        check("reset", "status", int'({wb_done, wb_error}), 0);
        check("reset", "retry", int'(retry_count), 0);
        repeat (2) @(posedge dsp_user_clk);
        #2 sys_reset_n = 1'b1;
        @(posedge dsp_user_clk); #2;
        check("reset", "ready_high", int'(bus.req_ready), 1);
        check("reset", "addr", int'(bus.dsp_cfg_mgmt_addr), 0);

        foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

        // Reset pulse in the middle of a read.
        v = mk(24'h0c0b0a, 0, NEVER, 4'b0000, 1, 0, 1, 0, 1);
        cur = v;
        clear_counts();
        bus.req_valid = 1'b1;
        bus.req_pri_bus = v.pri; bus.req_sec_bus = v.sec; bus.req_sub_bus = v.sub;
        @(posedge dsp_user_clk); #2;
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.dsp_cfg_mgmt_read && n < 20) begin
            @(posedge dsp_user_clk); #2; n++;
        end
        check("rst_rd", "read_seen", int'(bus.dsp_cfg_mgmt_read), 1);
        @(posedge dsp_user_clk); #2;
        sys_reset_n = 1'b0;
        #1;
        check("rst_rd", "read_drop", int'(bus.dsp_cfg_mgmt_read), 0);
        check("rst_rd", "ready_low", int'(bus.req_ready), 0);
        @(posedge dsp_user_clk); #2;
        sys_reset_n = 1'b1;
        repeat (3) begin
            @(posedge dsp_user_clk); #2;
        end
        check("rst_rd", "ready", int'(bus.req_ready), 1);
        check("rst_rd", "retry", int'(retry_count), 0);
        check("rst_rd", "no_pulse", dcnt + ecnt, 0);
        check("rst_rd", "no_strobe", int'({bus.dsp_cfg_mgmt_write, bus.dsp_cfg_mgmt_read}), 0);
        run_op(vecs[0], "after_rst");

        // req_valid held high with changing bus numbers: only accept-cycle values count.
        v = mk(24'h333231, 0, 0, 4'b0000, 1, 0, 1, 4, 1);
        cur = v;
        clear_counts();
        bus.req_valid = 1'b1;
        bus.req_pri_bus = v.pri; bus.req_sec_bus = v.sec; bus.req_sub_bus = v.sub;
        busy_ready = 0;
        n = 0;
        do begin
            @(posedge dsp_user_clk); #2; n++;
            if (bus.req_ready) busy_ready++;
            {bus.req_sub_bus, bus.req_sec_bus, bus.req_pri_bus} = 24'($urandom);
        end while (!wb_done && n < 50);
        check("hold", "latency", n, 4);
        check("hold", "busy_ready", busy_ready, 0);
        check("hold", "writes", writes, 1);
        check("hold", "retry", int'(retry_count), 0);
        check("hold", "protocol", viols, 0);
        v = mk(24'h5c5b5a, 0, 0, 4'b0000, 1, 0, 1, 4, 1);
        cur = v;
        writes = 0; viols = 0;
        bus.req_pri_bus = v.pri; bus.req_sec_bus = v.sec; bus.req_sub_bus = v.sub;
        @(posedge dsp_user_clk); #2;
        check("hold", "ready_after_done", int'(bus.req_ready), 1);
        @(posedge dsp_user_clk); #2;
        bus.req_valid = 1'b0;
        check("hold", "second_accepted", int'(bus.dsp_cfg_mgmt_write), 1);
        n = 0;
        while (!wb_done && n < 50) begin
            @(posedge dsp_user_clk); #2; n++;
        end
        check("hold", "second_latency", n, 3);
        check("hold", "second_writes", writes, 1);
        check("hold", "second_protocol", viols, 0);
        @(posedge dsp_user_clk); #2;

        // Random operations against the reference model, with stray done outside accesses.
        noise = 1'b1;
        for (int i = 0; i < 30; i++) begin
            v = mk(24'($urandom), 0, 0, 4'b0000, 0, 0, 0, 0, 0);
            for (int k = 0; k < 4; k++) begin
                int pick;
                pick = int'($urandom_range(0, 11));
                v.wdly[k] = (pick <= 8) ? 8'(pick % 5) : (pick == 9) ? 8'd15 : (pick == 10) ? 8'd16 : NEVER;
                pick = int'($urandom_range(0, 11));
                v.rdly[k] = (pick <= 9) ? 8'(pick % 5) : (pick == 10) ? 8'd15 : NEVER;
                v.bad[k]  = ($urandom_range(0, 2) == 0);
            end
            run_op(model(v), $sformatf("rnd%0d", i));
        end
        noise = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dsp_cfg_mgmt_bus_num_writer.md
DSP_CFG_MGMT_BUS_NUM_WRITER -- requirements
Module: dsp_cfg_mgmt_bus_num_writer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1023, max cycles an access waits for dsp_cfg_mgmt_read_write_done.
REQ-002 Parameter MAX_RETRIES, default 3, extra write+readback attempts after a failed attempt.
REQ-003 The block SHALL use clock dsp_user_clk; reset sys_reset_n, asynchronous, active-low.
REQ-004 Ports SHALL be:
- dsp_user_clk  in  1  clock
- sys_reset_n  in  1  async active-low reset
- req_valid  in  1  writeback request
- req_ready  out  1  block idle, request accepted when req_valid&&req_ready
- req_pri_bus / req_sec_bus / req_sub_bus  in  8 each  bus numbers to write
- dsp_cfg_mgmt_addr  out  10  DWORD address
- dsp_cfg_mgmt_function_number  out  8  function
- dsp_cfg_mgmt_write  out  1  write strobe
- dsp_cfg_mgmt_read  out  1  read strobe
- dsp_cfg_mgmt_write_data  out  32  write data
- dsp_cfg_mgmt_byte_enable  out  4  byte enables
- dsp_cfg_mgmt_read_data  in  32  read data, valid with done
- dsp_cfg_mgmt_read_write_done  in  1  access complete
- wb_done  out  1  one-cycle pulse, readback matched
- wb_error  out  1  one-cycle pulse, retries exhausted
- retry_count  out  2  failed attempts in current/last operation

Function
REQ-010 States SHALL be IDLE, WR, RD, CMP, DONE, ERR.
REQ-011 IDLE: req_ready=1; on accept, latch the three bus numbers, clear retry_count and timeout counter, go to WR next cycle.
REQ-012 In WR: dsp_cfg_mgmt_write=1, addr=10'h006, function_number=8'd0, byte_enable=4'b0111, write_data={8'h00, sub, sec, pri}, all held stable until done or timeout.
REQ-013 In RD: dsp_cfg_mgmt_read=1, addr=10'h006, function_number=8'd0, byte_enable=4'b1111; write and read SHALL never be asserted in the same cycle.
REQ-014 WR with done=1 SHALL go to RD next cycle (strobe deasserted for zero cycles between; read asserts the cycle after write deasserts).
REQ-015 RD with done=1 SHALL register dsp_cfg_mgmt_read_data[23:0] and go to CMP.
REQ-016 CMP: registered readback equal to latched {sub,sec,pri} -> DONE; else failed attempt.
REQ-017 Timeout counter increments each cycle in WR/RD, cleared on state entry; reaching TIMEOUT_CYCLES without done SHALL be a failed attempt, strobe deasserted next cycle.
REQ-018 Done and timeout in the same cycle: done wins.
REQ-019 Failed attempt: if retry_count < MAX_RETRIES, increment retry_count and return to WR; else go to ERR.
REQ-020 DONE and ERR each last exactly one cycle, assert wb_done / wb_error respectively, then IDLE; total latency with immediate done = accept + WR(1) + RD(1) + CMP(1) + DONE(1).
REQ-021 req_ready SHALL be 0 outside IDLE; req_valid outside IDLE is ignored, no queuing.
REQ-022 dsp_cfg_mgmt_read_write_done in IDLE, CMP, DONE, ERR SHALL be ignored.
REQ-023 retry_count saturates at MAX_RETRIES and holds its value in IDLE until the next accept.
REQ-024 Outside WR/RD, addr, function_number, write_data, byte_enable SHALL be 0.

Reset
REQ-030 sys_reset_n low SHALL immediately force IDLE, all outputs 0 except req_ready, which is 1 once reset deasserts; latched bus numbers, counters, readback cleared.
REQ-031 Reset mid-WR/RD SHALL drop the strobe asynchronously; no wb_done/wb_error produced for the aborted operation.

Verification
REQ-040 Request pri=0x01 sec=0x02 sub=0x05, done 3 cycles after each strobe, read_data=0x00050201 -> write_data=0x00050201, be=0x7, addr=0x006, wb_done pulse once, retry_count=0.
REQ-041 First readback 0x00000000, second 0x00050201 -> two writes, wb_done, retry_count=1.
REQ-042 done never asserted, TIMEOUT_CYCLES=15 -> 4 write attempts of 16 cycles each, wb_error pulse, retry_count=3.
REQ-043 done and timeout coincide on cycle 15 of WR -> proceeds to RD, retry_count=0.
REQ-044 sys_reset_n pulsed low during RD -> read drops same cycle, no status pulse, req_ready=1 after release; new request completes normally.
REQ-045 req_valid held high through an operation with changing bus values -> only the first-cycle values written; second request accepted only after DONE.
